// File: rtl/systolic_sched_ctrl.sv
// Sequencer for an output-stationary systolic array: operand intake, input skew, phase control.
// Optional bubble counter enabled by defining SYS_SCHED_PERF_EN.
module systolic_sched_ctrl #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int WORD_SIZE = 16,
  parameter int K_MAX     = 64,
  parameter int KW        = $clog2(K_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  output logic                      busy,
  output logic                      done,
  input  logic [ROWS*WORD_SIZE-1:0] a_vec,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [COLS*WORD_SIZE-1:0] b_vec,
  input  logic                      b_valid,
  output logic                      b_ready,
  output logic [ROWS*WORD_SIZE-1:0] left_in_bus,
  output logic [COLS*WORD_SIZE-1:0] top_in_bus,
  output logic                      ctl_stat_bit_in,
  output logic                      ctl_dummy_fsm_op2_select_in,
  output logic                      ctl_dummy_fsm_out_select_in,
  input  logic [COLS*WORD_SIZE-1:0] bottom_out_bus,
  output logic [COLS*WORD_SIZE-1:0] res_vec,
  output logic                      res_valid,
  output logic [15:0]               perf_bubbles
);

  localparam int PW = $clog2(ROWS + COLS + 1);
  localparam logic [KW-1:0] KMax      = KW'(K_MAX);
  localparam logic [PW-1:0] FlushLast = PW'(ROWS + COLS - 2);
  localparam logic [PW-1:0] DrainLast = PW'(ROWS);

  typedef enum logic [2:0] {StIdle, StClear, StCompute, StFlush, StDrain} state_e;

  state_e          r_state;
  logic [KW-1:0]   r_k_len;
  logic [KW-1:0]   r_cnt;
  logic [PW-1:0]   r_phase;
  logic            r_done;
  logic            r_stat;
  logic            r_op2;
  logic            r_out_sel;
  logic            r_res_valid;

  logic            w_window;
  logic            w_accept;
  logic            w_last_beat;
  logic [ROWS*WORD_SIZE-1:0] w_a_feed;
  logic [COLS*WORD_SIZE-1:0] w_b_feed;

  assign w_window    = (r_state == StCompute) && (r_cnt < r_k_len);
  assign w_accept    = w_window && a_valid && b_valid;
  assign w_last_beat = w_accept && ((r_cnt + KW'(1)) == r_k_len);

  assign a_ready = w_window && b_valid;
  assign b_ready = w_window && a_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_k_len     <= '0;
      r_cnt       <= '0;
      r_phase     <= '0;
      r_done      <= 1'b0;
      r_stat      <= 1'b0;
      r_op2       <= 1'b0;
      r_out_sel   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_k_len <= (k_len > KMax) ? KMax : k_len;
            r_cnt   <= '0;
            r_state <= StClear;
          end
        end
        StClear: begin
          r_op2 <= 1'b1;
          if (r_k_len == '0) begin
            r_state <= StFlush;
            r_phase <= FlushLast;
          end else begin
            r_state <= StCompute;
          end
        end
        StCompute: begin
          if (w_accept) begin
            r_cnt <= r_cnt + KW'(1);
            if (w_last_beat) begin
              r_state <= StFlush;
              r_phase <= FlushLast;
            end
          end
        end
        StFlush: begin
          if (r_phase == '0) begin
            r_state   <= StDrain;
            r_phase   <= DrainLast;
            r_op2     <= 1'b0;
            r_stat    <= 1'b1;
            r_out_sel <= 1'b1;
          end else begin
            r_phase <= r_phase - PW'(1);
          end
        end
        StDrain: begin
          // First drain cycle only moves the bottom row into the array's output register.
          if (r_phase == '0) begin
            r_state     <= StIdle;
            r_stat      <= 1'b0;
            r_out_sel   <= 1'b0;
            r_res_valid <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_phase     <= r_phase - PW'(1);
            r_res_valid <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy                        = (r_state != StIdle);
  assign done                        = r_done;
  assign ctl_stat_bit_in             = r_stat;
  assign ctl_dummy_fsm_op2_select_in = r_op2;
  assign ctl_dummy_fsm_out_select_in = r_out_sel;
  assign res_valid                   = r_res_valid;
  assign res_vec                     = r_res_valid ? bottom_out_bus : '0;

  // Non-accepting cycles feed zeros so the accumulators see a harmless bubble.
  assign w_a_feed = w_accept ? a_vec : '0;
  assign w_b_feed = w_accept ? b_vec : '0;

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row_skew
    logic [WORD_SIZE-1:0] w_in;
    assign w_in = w_a_feed[gr*WORD_SIZE +: WORD_SIZE];
    if (gr == 0) begin : g_direct
      assign left_in_bus[gr*WORD_SIZE +: WORD_SIZE] = w_in;
    end else begin : g_delay
      logic [WORD_SIZE-1:0] r_dly [gr];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < gr; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= w_in;
          for (int i = 1; i < gr; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign left_in_bus[gr*WORD_SIZE +: WORD_SIZE] = r_dly[gr-1];
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_col_skew
    logic [WORD_SIZE-1:0] w_in;
    assign w_in = w_b_feed[gc*WORD_SIZE +: WORD_SIZE];
    if (gc == 0) begin : g_direct
      assign top_in_bus[gc*WORD_SIZE +: WORD_SIZE] = w_in;
    end else begin : g_delay
      logic [WORD_SIZE-1:0] r_dly [gc];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < gc; i++) r_dly[i] <= '0;
        end else begin
          r_dly[0] <= w_in;
          for (int i = 1; i < gc; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign top_in_bus[gc*WORD_SIZE +: WORD_SIZE] = r_dly[gc-1];
    end
  end

`ifdef SYS_SCHED_PERF_EN
  logic [15:0] r_perf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_perf <= '0;
    end else if (w_window && !w_accept && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end
  assign perf_bubbles = r_perf;
`else
  assign perf_bubbles = 16'h0;
`endif

endmodule
